// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - request/response bundle between memory stage and data-memory responder
interface dmem_responder_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [63:0] req_addr_i;
    logic [63:0] req_wdata_i;
    logic        flush_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [63:0] rsp_rdata_o;
    logic        rsp_err_o;

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, flush_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i, flush_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency quadword data memory; DMEM_BOUNDS_CHECK_EN enables address error instead of wrap
module dmem_responder #(
    parameter int SIZE    = 1024,
    parameter int LATENCY = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    dmem_responder_if.slave   bus
);
    localparam int AW = $clog2(SIZE);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q;
    logic [63:0]   addr_q;
    logic [63:0]   wdata_q;
    logic [63:0]   rdata_q;
    logic          err_q;

    logic [7:0]    mem_q [SIZE] = '{default: 8'h00};
    logic [AW-1:0] idx [8];
    logic [63:0]   mem_rdata;
    logic          addr_err;
    logic          accept;
    logic          access;
    logic          unused_addr;

    assign accept = bus.req_valid_i && (state_q == S_IDLE);
    // Flush wins over completion, so it also suppresses the access itself.
    assign access = (state_q == S_BUSY) && (cnt_q == '0) && !bus.flush_i;

`ifdef DMEM_BOUNDS_CHECK_EN
    assign addr_err = (addr_q > 64'(SIZE - 8));
`else
    assign addr_err = 1'b0;
`endif
    assign unused_addr = ^addr_q[63:AW];

    always_comb begin
        idx       = '{default: '0};
        mem_rdata = '0;
        for (int k = 0; k < 8; k++) begin
            idx[k]               = addr_q[AW-1:0] + AW'(k);
            mem_rdata[8*k +: 8]  = mem_q[idx[k]];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid_i) begin
                    state_d = S_BUSY;
                    cnt_d   = CW'(LATENCY - 1);
                end
            end
            S_BUSY: begin
                if (bus.flush_i) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_RESP: begin
                if (bus.rsp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= bus.req_we_i;
                addr_q  <= bus.req_addr_i;
                wdata_q <= bus.req_wdata_i;
            end
            if (access) begin
                err_q   <= addr_err;
                rdata_q <= (we_q || addr_err) ? '0 : mem_rdata;
            end else if ((state_q == S_RESP) && bus.rsp_ready_i) begin
                err_q   <= 1'b0;
                rdata_q <= '0;
            end
        end
    end

    // Memory is deliberately outside the reset domain; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (access && we_q && !addr_err) begin
            for (int k = 0; k < 8; k++) begin
                mem_q[idx[k]] <= wdata_q[8*k +: 8];
            end
        end
    end

    assign bus.req_ready_o = (state_q == S_IDLE);
    assign bus.rsp_valid_o = (state_q == S_RESP);
    assign bus.rsp_rdata_o = rdata_q;
    assign bus.rsp_err_o   = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - vector table plus flush/reset sequences with an expected-response queue
module tb_dmem_responder;
    localparam int LAT = 2;
`ifdef DMEM_BOUNDS_CHECK_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
        logic        exp_err;
        int          stall;
    } vec_t;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t sb[$];
    vec_t vecs[14];

    dmem_responder_if bus();

    dmem_responder #(.SIZE(1024), .LATENCY(LAT)) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int   cyc;
        exp_t e;
        @(negedge clk);
        bus.req_valid_i = 1'b1;
        bus.req_we_i    = v.we;
        bus.req_addr_i  = v.addr;
        bus.req_wdata_i = v.wdata;
        cyc = 0;
        while (!bus.req_ready_o && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        @(posedge clk);
        #1;
        bus.req_valid_i = 1'b0;
        bus.req_we_i    = ~v.we;
        bus.req_addr_i  = {$urandom, $urandom};
        bus.req_wdata_i = {$urandom, $urandom};
        sb.push_back('{rdata: v.exp_rdata, err: v.exp_err});
        check({nm, " ready_busy"}, 64'(bus.req_ready_o), 64'd0);
        cyc = 0;
        while (!bus.rsp_valid_o && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({nm, " latency"}, 64'(cyc), 64'(LAT));
        e = sb.pop_front();
        check({nm, " rdata"}, bus.rsp_rdata_o, e.rdata);
        check({nm, " err"}, 64'(bus.rsp_err_o), 64'(e.err));
        // Flush is held high during the stall; it must be ignored in RESP.
        for (int s = 0; s < v.stall; s++) begin
            bus.flush_i = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("%s stall%0d valid", nm, s), 64'(bus.rsp_valid_o), 64'd1);
            check($sformatf("%s stall%0d rdata", nm, s), bus.rsp_rdata_o, e.rdata);
            check($sformatf("%s stall%0d ready", nm, s), 64'(bus.req_ready_o), 64'd0);
        end
        bus.flush_i     = 1'b0;
        bus.rsp_ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready_i = 1'b0;
        check({nm, " done_valid"}, 64'(bus.rsp_valid_o), 64'd0);
        check({nm, " done_ready"}, 64'(bus.req_ready_o), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t rd;
        bus.req_valid_i = 1'b0;
        bus.req_we_i    = 1'b0;
        bus.req_addr_i  = '0;
        bus.req_wdata_i = '0;
        bus.flush_i     = 1'b0;
        bus.rsp_ready_i = 1'b0;

        vecs[0]  = '{1'b1, 64'h10, 64'h1122334455667788, 64'h0, 1'b0, 0};
        vecs[1]  = '{1'b0, 64'h10, 64'h0, 64'h1122334455667788, 1'b0, 5};
        vecs[2]  = '{1'b0, 64'h13, 64'h0, 64'h0000001122334455, 1'b0, 0};
        vecs[3]  = '{1'b1, 64'h20, 64'h0123456789ABCDEF, 64'h0, 1'b0, 1};
        vecs[4]  = '{1'b0, 64'h20, 64'h0, 64'h0123456789ABCDEF, 1'b0, 2};
        vecs[5]  = '{1'b0, 64'h1C, 64'h0, 64'h89ABCDEF00000000, 1'b0, 0};
        vecs[6]  = '{1'b1, 64'd1016, 64'h0807060504030201, 64'h0, 1'b0, 0};
        vecs[7]  = '{1'b1, 64'd1017, 64'hFFFFFFFFFFFFFFFF, 64'h0, BC, 0};
        vecs[8]  = '{1'b0, 64'd1016, 64'h0,
                     BC ? 64'h0807060504030201 : 64'hFFFFFFFFFFFFFF01, 1'b0, 0};
        vecs[9]  = '{1'b1, 64'd1020, 64'hAABBCCDDEEFF0011, 64'h0, BC, 0};
        vecs[10] = '{1'b0, 64'd0, 64'h0, BC ? 64'h0 : 64'h00000000AABBCCDD, 1'b0, 0};
        vecs[11] = '{1'b0, 64'd1016, 64'h0,
                     BC ? 64'h0807060504030201 : 64'hEEFF0011FFFFFF01, 1'b0, 0};
        vecs[12] = '{1'b0, 64'h8000000000000010, 64'h0,
                     BC ? 64'h0 : 64'h1122334455667788, BC, 0};
        vecs[13] = '{1'b0, 64'd1017, 64'h0, BC ? 64'h0 : 64'hDDEEFF0011FFFFFF, BC, 0};

        repeat (3) @(posedge clk);
        #1;
        check("rst rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
        check("rst rdata", bus.rsp_rdata_o, 64'd0);
        check("rst err", 64'(bus.rsp_err_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst req_ready", 64'(bus.req_ready_o), 64'd1);

        for (int i = 0; i < 14; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Flush landing on the access edge of a write to 0x20.
        @(negedge clk);
        bus.req_valid_i = 1'b1;
        bus.req_we_i    = 1'b1;
        bus.req_addr_i  = 64'h20;
        bus.req_wdata_i = 64'hDEADBEEFCAFEF00D;
        @(posedge clk);
        #1;
        bus.req_valid_i = 1'b0;
        @(posedge clk);
        #1;
        bus.flush_i = 1'b1;
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
        check("flush rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
        check("flush req_ready", 64'(bus.req_ready_o), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        check("flush no_late_rsp", 64'(bus.rsp_valid_o), 64'd0);
        rd = '{1'b0, 64'h20, 64'h0, 64'h0123456789ABCDEF, 1'b0, 0};
        run_vec(rd, "flush readback");

        // Reset pulse while a write to 0x10 is in BUSY.
        @(negedge clk);
        bus.req_valid_i = 1'b1;
        bus.req_we_i    = 1'b1;
        bus.req_addr_i  = 64'h10;
        bus.req_wdata_i = 64'hFFFFFFFFFFFFFFFF;
        @(posedge clk);
        #1;
        bus.req_valid_i = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
        check("midrst rdata", bus.rsp_rdata_o, 64'd0);
        check("midrst err", 64'(bus.rsp_err_o), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst req_ready", 64'(bus.req_ready_o), 64'd1);
        rd = '{1'b0, 64'h10, 64'h0, 64'h1122334455667788, 1'b0, 0};
        run_vec(rd, "midrst readback");

        check("scoreboard empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
